// File: rtl/feature_addr_gen_if.sv
// feature_addr_gen_if: command (base/stride/len) and address-beat valid/ready bundle; slave = sequencer side, master = environment side
interface feature_addr_gen_if #(
  parameter int W_ADDR = 12,
  parameter int W_LEN  = 6
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [W_ADDR-1:0] cmd_base;
  logic [W_ADDR-1:0] cmd_stride;
  logic [W_LEN-1:0]  cmd_len;
  logic              addr_valid;
  logic              addr_ready;
  logic [W_ADDR-1:0] addr_data;
  logic              addr_last;
  modport slave (
    input  cmd_valid, cmd_base, cmd_stride, cmd_len, addr_ready,
    output cmd_ready, addr_valid, addr_data, addr_last
  );
  modport master (
    output cmd_valid, cmd_base, cmd_stride, cmd_len, addr_ready,
    input  cmd_ready, addr_valid, addr_data, addr_last
  );
endinterface

// File: rtl/feature_addr_gen.sv
// feature_addr_gen: burst BRAM read-address sequencer; ports clk, rst (sync, active-high), bus (cmd in / addr beats out), busy (burst running), done (1-cycle completion pulse)
module feature_addr_gen #(
  parameter int W_ADDR = 12,
  parameter int W_LEN  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  feature_addr_gen_if.slave        bus,
  output logic                     busy,
  output logic                     done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t            state;
  logic [W_ADDR-1:0] addr_q;
  logic [W_ADDR-1:0] stride_q;
  logic [W_LEN-1:0]  rem;
  assign bus.cmd_ready  = state == IDLE && !rst;
  assign bus.addr_valid = state == RUN;
  assign bus.addr_data  = addr_q;
  assign bus.addr_last  = state == RUN && rem == W_LEN'(1);
  assign busy           = state == RUN;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      rem      <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (bus.cmd_valid) begin
          addr_q   <= bus.cmd_base;
          stride_q <= bus.cmd_stride;
          rem      <= bus.cmd_len;
          if (bus.cmd_len != '0) state <= RUN;
          else done <= 1'b1;
        end
      end else if (bus.addr_ready) begin
        addr_q <= addr_q + stride_q;
        rem    <= rem - W_LEN'(1);
        if (rem == W_LEN'(1)) begin
          state <= IDLE;
          done  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_feature_addr_gen.sv
// tb_feature_addr_gen: scoreboard bench for feature_addr_gen
module tb_feature_addr_gen;
  localparam int WA = 12;
  localparam int WL = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, done;
  int asserts = 0;
  int fails = 0;
  int n_beats = 0;
  int n_done = 0;
  logic [WA:0] exp_q[$];
  logic [WA:0] obs_q[$];
  logic [WA:0] o, e;
  always #5 clk = ~clk;
  feature_addr_gen_if #(.W_ADDR(WA), .W_LEN(WL)) bus ();
  feature_addr_gen #(.W_ADDR(WA), .W_LEN(WL)) dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy), .done(done));
  always @(negedge clk) begin
    if (!rst && done) n_done++;
    if (!rst && bus.addr_valid && bus.addr_ready) begin
      n_beats++;
      obs_q.push_back({bus.addr_last, bus.addr_data});
    end
  end
  task automatic push_exp(input logic [WA-1:0] b, input logic [WA-1:0] s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, WA'(b + s * i)});
  endtask
  task automatic send_cmd(input logic [WA-1:0] b, input logic [WA-1:0] s, input logic [WL-1:0] l);
    int waited;
    push_exp(b, s, int'(l));
    bus.cmd_base = b;
    bus.cmd_stride = s;
    bus.cmd_len = l;
    bus.cmd_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!bus.cmd_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    asserts++;
    if (!bus.cmd_ready) begin fails++; $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, waited); end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask
  task automatic test_reset;
    bus.cmd_valid = 1'b1;
    bus.cmd_base = 12'h055;
    bus.cmd_stride = 12'h001;
    bus.cmd_len = 6'd4;
    bus.addr_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      asserts++;
      if ({bus.cmd_ready, bus.addr_valid, bus.addr_last, busy, done, bus.addr_data} !== '0)
        begin fails++; $display("FAIL reset_outputs: rdy=%b v=%b last=%b busy=%b done=%b data=%h, required all 0", bus.cmd_ready, bus.addr_valid, bus.addr_last, busy, done, bus.addr_data); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    asserts++;
    if ({bus.cmd_ready, busy, bus.addr_valid, done} !== 4'b1000)
      begin fails++; $display("FAIL reset_release: rdy,busy,v,done=%b, required 1000", {bus.cmd_ready, busy, bus.addr_valid, done}); end
    @(posedge clk); #1;
  endtask
  task automatic test_basic;
    int b0, d0;
    b0 = n_beats; d0 = n_done;
    bus.addr_ready = 1'b1;
    send_cmd(12'h010, 12'h001, 6'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      asserts++;
      if (bus.addr_valid !== 1'b1) begin fails++; $display("FAIL basic_valid beat %0d: got %b, required 1", i, bus.addr_valid); end
    end
    @(negedge clk);
    asserts++;
    if ({done, busy, bus.cmd_ready, bus.addr_valid} !== 4'b1010)
      begin fails++; $display("FAIL basic_done: done,busy,rdy,v=%b, required 1010", {done, busy, bus.cmd_ready, bus.addr_valid}); end
    @(negedge clk);
    asserts++;
    if (done !== 1'b0) begin fails++; $display("FAIL basic_done_width: done=%b, required 0", done); end
    @(posedge clk); #1;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); asserts++;
      if (exp_q.size() == 0) begin fails++; $display("FAIL basic_extra_beat: got %h, required none", o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin fails++; $display("FAIL basic_beat: got last,addr=%h, required %h", o, e); end end
    end
    asserts++;
    if (n_beats - b0 !== 4 || n_done - d0 !== 1)
      begin fails++; $display("FAIL basic_counts: beats=%0d dones=%0d, required 4 and 1", n_beats - b0, n_done - d0); end
  endtask
  task automatic test_backpressure;
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [WA:0] prev;
    logic prev_fire;
    int b0, d0;
    b0 = n_beats; d0 = n_done;
    prev = '0; prev_fire = 1'b1;
    send_cmd(12'h100, 12'h020, 6'd3);
    for (int i = 0; i < 6; i++) begin
      bus.addr_ready = pat[i];
      @(negedge clk);
      asserts++;
      if (bus.addr_valid !== 1'b1 || (!prev_fire && {bus.addr_last, bus.addr_data} !== prev))
        begin fails++; $display("FAIL bp_stall cycle %0d: v=%b last,addr=%h, required v=1 and stable %h", i, bus.addr_valid, {bus.addr_last, bus.addr_data}, prev); end
      prev = {bus.addr_last, bus.addr_data};
      prev_fire = pat[i];
      @(posedge clk); #1;
    end
    bus.addr_ready = 1'b1;
    @(negedge clk);
    asserts++;
    if ({done, busy, bus.addr_valid} !== 3'b100)
      begin fails++; $display("FAIL bp_done: done,busy,v=%b, required 100", {done, busy, bus.addr_valid}); end
    @(posedge clk); #1;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); asserts++;
      if (exp_q.size() == 0) begin fails++; $display("FAIL bp_extra_beat: got %h, required none", o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin fails++; $display("FAIL bp_beat: got last,addr=%h, required %h", o, e); end end
    end
    asserts++;
    if (n_beats - b0 !== 3 || n_done - d0 !== 1)
      begin fails++; $display("FAIL bp_counts: beats=%0d dones=%0d, required 3 and 1", n_beats - b0, n_done - d0); end
  endtask
  task automatic test_wrap_zero;
    int b0, d0;
    b0 = n_beats; d0 = n_done;
    bus.addr_ready = 1'b1;
    send_cmd(12'hFFE, 12'h001, 6'd3);
    repeat (3) @(negedge clk);
    @(negedge clk);
    asserts++;
    if (done !== 1'b1) begin fails++; $display("FAIL wrap_done: done=%b, required 1", done); end
    @(posedge clk); #1;
    send_cmd(12'h123, 12'h005, 6'd0);
    @(negedge clk);
    asserts++;
    if ({done, bus.cmd_ready, bus.addr_valid, busy} !== 4'b1100)
      begin fails++; $display("FAIL zero_len_done: done,rdy,v,busy=%b, required 1100", {done, bus.cmd_ready, bus.addr_valid, busy}); end
    @(posedge clk); #1;
    @(negedge clk);
    asserts++;
    if ({done, bus.cmd_ready} !== 2'b01) begin fails++; $display("FAIL zero_len_after: done,rdy=%b, required 01", {done, bus.cmd_ready}); end
    @(posedge clk); #1;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); asserts++;
      if (exp_q.size() == 0) begin fails++; $display("FAIL wrap_extra_beat: got %h, required none", o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin fails++; $display("FAIL wrap_beat: got last,addr=%h, required %h", o, e); end end
    end
    asserts++;
    if (n_beats - b0 !== 3 || n_done - d0 !== 2)
      begin fails++; $display("FAIL wrap_counts: beats=%0d dones=%0d, required 3 and 2", n_beats - b0, n_done - d0); end
  endtask
  task automatic test_back_to_back;
    int k;
    bus.addr_ready = 1'b1;
    send_cmd(12'h200, 12'h003, 6'd3);
    push_exp(12'h300, 12'h002, 2);
    bus.cmd_base = 12'h300;
    bus.cmd_stride = 12'h002;
    bus.cmd_len = 6'd2;
    bus.cmd_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.cmd_ready && k < 20) begin
      k++;
      @(negedge clk);
    end
    asserts++;
    if (k !== 3) begin fails++; $display("FAIL b2b_accept_cycle: accepted %0d cycles after first beat, required 3", k); end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    asserts++;
    if (bus.addr_valid !== 1'b1 || bus.addr_data !== 12'h300)
      begin fails++; $display("FAIL b2b_first_beat: v=%b addr=%h, required 1 and 300", bus.addr_valid, bus.addr_data); end
    @(negedge clk);
    @(negedge clk);
    asserts++;
    if (done !== 1'b1) begin fails++; $display("FAIL b2b_done: done=%b, required 1", done); end
    @(posedge clk); #1;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); asserts++;
      if (exp_q.size() == 0) begin fails++; $display("FAIL b2b_extra_beat: got %h, required none", o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin fails++; $display("FAIL b2b_beat: got last,addr=%h, required %h", o, e); end end
    end
  endtask
  task automatic test_reset_mid;
    int d0;
    bus.addr_ready = 1'b1;
    send_cmd(12'h040, 12'h004, 6'd10);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    d0 = n_done;
    @(posedge clk); #1;
    rst = 1'b0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); asserts++;
      if (exp_q.size() == 0) begin fails++; $display("FAIL rstmid_extra_beat: got %h, required none", o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin fails++; $display("FAIL rstmid_beat: got last,addr=%h, required %h", o, e); end end
    end
    asserts++;
    if (exp_q.size() !== 6) begin fails++; $display("FAIL rstmid_beats_before: remaining expected %0d, required 6", exp_q.size()); end
    exp_q.delete();
    @(negedge clk);
    asserts++;
    if ({bus.addr_valid, busy, done, bus.cmd_ready} !== 4'b0001)
      begin fails++; $display("FAIL rstmid_abandon: v,busy,done,rdy=%b, required 0001", {bus.addr_valid, busy, done, bus.cmd_ready}); end
    @(posedge clk); #1;
    @(negedge clk);
    asserts++;
    if (done !== 1'b0 || n_done !== d0) begin fails++; $display("FAIL rstmid_no_done: done=%b pulses=%0d, required 0 and 0", done, n_done - d0); end
    @(posedge clk); #1;
    send_cmd(12'h500, 12'h001, 6'd2);
    repeat (2) @(negedge clk);
    @(negedge clk);
    asserts++;
    if (done !== 1'b1) begin fails++; $display("FAIL rstmid_restart_done: done=%b, required 1", done); end
    @(posedge clk); #1;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); asserts++;
      if (exp_q.size() == 0) begin fails++; $display("FAIL restart_extra_beat: got %h, required none", o); end
      else begin e = exp_q.pop_front(); if (o !== e) begin fails++; $display("FAIL restart_beat: got last,addr=%h, required %h", o, e); end end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap_zero();
    test_back_to_back();
    test_reset_mid();
    asserts++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL missing_beats: %0d expected beats never seen, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
